tx_iq_ctrl: RTL and testbench
=============================

TX_IQ_CTRL -- requirements
Module: tx_iq_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 11: width of FIFO occupancy and threshold buses.
REQ-002 Parameter FLUSH_CYCLES, default 4: idle cycles after a FIFO flush before a new packet is accepted.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 src_sel_req  in  1  requested source from register (0 = tx core, 1 = s_axis).
REQ-006 pkt_start  in  1  one-cycle pulse: tx core begins writing a packet into the I/Q FIFO.
REQ-007 pkt_end  in  1  one-cycle pulse: tx core has written the last sample of the packet.
REQ-008 prefill_threshold  in  CNT_WIDTH  occupancy required before readout starts.
REQ-009 tx_hold_threshold  in  CNT_WIDTH  occupancy above which the tx core is held.
REQ-010 fifo_data_count  in  CNT_WIDTH  I/Q FIFO occupancy.
REQ-011 fifo_empty  in  1  I/Q FIFO empty flag.
REQ-012 wifi_iq_ready  in  1  RF side consumes one sample this cycle.
REQ-013 src_sel  out  1  applied source select to the I/Q datapath.
REQ-014 fifo_rden_gate  out  1  permits FIFO read (datapath ANDs with wifi_iq_ready).
REQ-015 fifo_flush  out  1  one-cycle FIFO reset pulse.
REQ-016 tx_hold  out  1  registered hold to tx core.
REQ-017 tx_active / tx_done  out  1 each  packet in flight / one-cycle completion pulse.
REQ-018 underrun_cnt  out  16  saturating underrun counter.
REQ-019 ctrl_state  out  3  current FSM state encoding.

Function
REQ-020 FSM states SHALL be IDLE(0), PREFILL(1), STREAM(2), FLUSH(3), SETTLE(4); all other codes return to IDLE.
REQ-021 IDLE: pkt_start -> PREFILL; else src_sel_req != src_sel -> FLUSH; pkt_start wins if both occur the same cycle.
REQ-022 pkt_start is ignored in PREFILL, STREAM, FLUSH, SETTLE.
REQ-023 An end_seen flag SHALL set on pkt_end in PREFILL/STREAM, or with pkt_start in IDLE; it clears on entering IDLE.
REQ-024 PREFILL -> STREAM on fifo_data_count >= prefill_threshold or end_seen (flag or same-cycle pkt_end).
REQ-025 fifo_rden_gate SHALL be 1 only in STREAM with src_sel = 0; tx_active SHALL be 1 in PREFILL and STREAM.
REQ-026 STREAM: end_seen and fifo_empty -> IDLE with tx_done pulsed on the transition cycle.
REQ-027 STREAM: wifi_iq_ready and fifo_empty and not end_seen is an underrun; underrun_cnt increments by 1 per cycle, saturating at 0xFFFF.
REQ-028 FLUSH lasts exactly 1 cycle with fifo_flush = 1; src_sel updates to src_sel_req on the FLUSH->SETTLE edge.
REQ-029 SETTLE lasts FLUSH_CYCLES cycles, then returns to IDLE; src_sel_req changes during FLUSH/SETTLE are re-evaluated in IDLE.
REQ-030 tx_hold SHALL register (fifo_data_count > tx_hold_threshold), 1 cycle latency, and be forced 1 in FLUSH and SETTLE.
REQ-031 A prefill_threshold of 0 SHALL pass PREFILL in one cycle.

Reset
REQ-032 On rst: state IDLE, src_sel 0, fifo_rden_gate 0, fifo_flush 0, tx_hold 0, tx_active 0, tx_done 0, underrun_cnt 0, end_seen 0.
REQ-033 rst asserted mid-packet SHALL abandon the packet without a tx_done pulse.

Configuration
REQ-034 Macro TX_IQ_CTRL_UNDERRUN_CNT_EN defined: underrun_cnt is implemented per REQ-027.
REQ-035 Macro not defined: underrun_cnt is tied to 0 and no counter logic is built.

Structure
REQ-036 State encodings and the underrun counter width SHALL be in a shared package tx_intf_pkg.
REQ-037 The block is flat; no sub-module.

Verification
REQ-038 prefill_threshold=64, pkt_start, 100 samples written, pkt_end -> STREAM when count reaches 64, gate 1, tx_done after FIFO drains, IDLE.
REQ-039 pkt_start and pkt_end in one cycle, 10 samples, threshold 64 -> STREAM after 1 PREFILL cycle, tx_done after 10 reads.
REQ-040 STREAM, FIFO empty, ready high 5 cycles, no pkt_end -> underrun_cnt=5; with underrun_cnt preset to 0xFFFE -> 0xFFFF, holds.
REQ-041 IDLE, src_sel_req 0->1 -> fifo_flush 1 cycle, src_sel=1 next cycle, tx_hold 1 for 5 cycles, IDLE after 4 SETTLE cycles.
REQ-042 src_sel_req toggle and pkt_start same cycle -> PREFILL, no flush; flush follows tx_done.
REQ-043 rst asserted in STREAM -> all outputs at reset values asynchronously, no tx_done.

Source files
------------

// File: rtl/tx_intf_pkg.sv
// Shared definitions for the TX I/Q control path: FSM encodings and underrun counter sizing.
package tx_intf_pkg;

    localparam int unsigned UnderrunCntWidth = 16;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPrefill = 3'd1,
        StStream  = 3'd2,
        StFlush   = 3'd3,
        StSettle  = 3'd4
    } ctrl_state_e;

    function automatic logic [UnderrunCntWidth-1:0] underrun_sat_inc(
        input logic [UnderrunCntWidth-1:0] val
    );
        return (&val) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/tx_iq_ctrl_if.sv
// I/Q FIFO / packet handshake bundle between the TX controller and the datapath.
interface tx_iq_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 11
) ();

    logic                 pkt_start;
    logic                 pkt_end;
    logic [CNT_WIDTH-1:0] fifo_data_count;
    logic                 fifo_empty;
    logic                 wifi_iq_ready;
    logic                 fifo_rden_gate;
    logic                 fifo_flush;
    logic                 tx_hold;
    logic                 tx_active;
    logic                 tx_done;

    // Controller side.
    modport master (
        input  pkt_start, pkt_end, fifo_data_count, fifo_empty, wifi_iq_ready,
        output fifo_rden_gate, fifo_flush, tx_hold, tx_active, tx_done
    );

    // Datapath / tx core side.
    modport slave (
        output pkt_start, pkt_end, fifo_data_count, fifo_empty, wifi_iq_ready,
        input  fifo_rden_gate, fifo_flush, tx_hold, tx_active, tx_done
    );

endinterface

// File: rtl/tx_iq_ctrl.sv
// TX I/Q FIFO controller: prefill, stream, source-switch flush/settle and underrun counting.
// Define TX_IQ_CTRL_UNDERRUN_CNT_EN to build the saturating underrun counter.
module tx_iq_ctrl
    import tx_intf_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = 11,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_src_sel_req,
    input  logic [CNT_WIDTH-1:0]        i_prefill_threshold,
    input  logic [CNT_WIDTH-1:0]        i_tx_hold_threshold,
    tx_iq_ctrl_if.master                io_iq,
    output logic                        o_src_sel,
    output logic [UnderrunCntWidth-1:0] o_underrun_cnt,
    output logic [2:0]                  o_ctrl_state
);

    localparam int unsigned SettleW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [SettleW-1:0] SettleLast = SettleW'(FLUSH_CYCLES - 1);

    ctrl_state_e        r_state;
    ctrl_state_e        w_state_nxt;
    logic               r_end_seen;
    logic               w_end_seen;
    logic               w_done;
    logic [SettleW-1:0] r_settle_cnt;
    logic               r_src_sel;
    logic               r_rden_gate;
    logic               r_flush;
    logic               r_tx_hold;
    logic               r_tx_active;
    logic               r_tx_done;

    always_comb begin
        // A same-cycle pkt_end counts as already seen while a packet is in flight.
        w_end_seen  = r_end_seen |
                      (io_iq.pkt_end & ((r_state == StPrefill) | (r_state == StStream)));
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            StIdle: begin
                if (io_iq.pkt_start) begin
                    w_state_nxt = StPrefill;
                end else if (i_src_sel_req != r_src_sel) begin
                    w_state_nxt = StFlush;
                end
            end
            StPrefill: begin
                if ((io_iq.fifo_data_count >= i_prefill_threshold) || w_end_seen) begin
                    w_state_nxt = StStream;
                end
            end
            StStream: begin
                if (w_end_seen && io_iq.fifo_empty) begin
                    w_state_nxt = StIdle;
                    w_done      = 1'b1;
                end
            end
            StFlush:  w_state_nxt = StSettle;
            StSettle: begin
                if (r_settle_cnt == SettleLast) begin
                    w_state_nxt = StIdle;
                end
            end
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_end_seen   <= 1'b0;
            r_settle_cnt <= '0;
            r_src_sel    <= 1'b0;
            r_rden_gate  <= 1'b0;
            r_flush      <= 1'b0;
            r_tx_hold    <= 1'b0;
            r_tx_active  <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_end_seen   <= (w_state_nxt != StIdle) &
                            (w_end_seen | ((r_state == StIdle) & io_iq.pkt_start & io_iq.pkt_end));
            r_settle_cnt <= (r_state == StSettle) ? r_settle_cnt + 1'b1 : '0;
            if (r_state == StFlush) begin
                r_src_sel <= i_src_sel_req;
            end
            // Outputs are registered from the next state so they line up with o_ctrl_state.
            r_rden_gate  <= (w_state_nxt == StStream) & ~r_src_sel;
            r_flush      <= (w_state_nxt == StFlush);
            r_tx_active  <= (w_state_nxt == StPrefill) | (w_state_nxt == StStream);
            r_tx_done    <= w_done;
            r_tx_hold    <= (io_iq.fifo_data_count > i_tx_hold_threshold) |
                            (w_state_nxt == StFlush) | (w_state_nxt == StSettle);
        end
    end

`ifdef TX_IQ_CTRL_UNDERRUN_CNT_EN
    logic                        w_underrun;
    logic [UnderrunCntWidth-1:0] r_underrun_cnt;

    assign w_underrun = (r_state == StStream) & io_iq.wifi_iq_ready & io_iq.fifo_empty &
                        ~w_end_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun) begin
            r_underrun_cnt <= underrun_sat_inc(r_underrun_cnt);
        end
    end

    assign o_underrun_cnt = r_underrun_cnt;
`else
    assign o_underrun_cnt = '0;
`endif

    assign io_iq.fifo_rden_gate = r_rden_gate;
    assign io_iq.fifo_flush     = r_flush;
    assign io_iq.tx_hold        = r_tx_hold;
    assign io_iq.tx_active      = r_tx_active;
    assign io_iq.tx_done        = r_tx_done;
    assign o_src_sel            = r_src_sel;
    assign o_ctrl_state         = r_state;

endmodule

// File: tb/tb_tx_iq_ctrl.sv
// Directed self-checking bench for tx_iq_ctrl; honours TX_IQ_CTRL_UNDERRUN_CNT_EN when defined.
module tb_tx_iq_ctrl;

    logic        clk;
    logic        rst;
    logic        src_sel_req;
    logic [10:0] prefill_thr;
    logic [10:0] hold_thr;
    logic        src_sel;
    logic [15:0] underrun_cnt;
    logic [2:0]  ctrl_state;

    int n_pass;
    int n_fail;
    int n_total;

    tx_iq_ctrl_if #(.CNT_WIDTH(11)) iq ();

    tx_iq_ctrl #(
        .CNT_WIDTH   (11),
        .FLUSH_CYCLES(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_src_sel_req      (src_sel_req),
        .i_prefill_threshold(prefill_thr),
        .i_tx_hold_threshold(hold_thr),
        .io_iq              (iq),
        .o_src_sel          (src_sel),
        .o_underrun_cnt     (underrun_cnt),
        .o_ctrl_state       (ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fifo(input int n);
        iq.fifo_data_count = 11'(n);
        iq.fifo_empty      = (n == 0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_pass = 0;
        n_fail = 0;
        n_total = 0;
        rst = 1'b0;
        src_sel_req = 1'b0;
        prefill_thr = 11'd64;
        hold_thr = 11'd2000;
        iq.pkt_start = 1'b0;
        iq.pkt_end = 1'b0;
        iq.wifi_iq_ready = 1'b0;
        set_fifo(0);

        // Reset values
        #2 rst = 1'b1;
        #1;
        check("rst_state", 32'(ctrl_state), 0);
        check("rst_src_sel", 32'(src_sel), 0);
        check("rst_gate", 32'(iq.fifo_rden_gate), 0);
        check("rst_flush", 32'(iq.fifo_flush), 0);
        check("rst_hold", 32'(iq.tx_hold), 0);
        check("rst_active", 32'(iq.tx_active), 0);
        check("rst_done", 32'(iq.tx_done), 0);
        check("rst_underrun", 32'(underrun_cnt), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_after_rst", 32'(ctrl_state), 0);

        // Normal packet, prefill to 64, 100 samples
        iq.pkt_start = 1'b1;
        tick();
        iq.pkt_start = 1'b0;
        check("p1_prefill", 32'(ctrl_state), 1);
        check("p1_active", 32'(iq.tx_active), 1);
        check("p1_gate_prefill", 32'(iq.fifo_rden_gate), 0);
        for (int i = 1; i < 64; i++) begin
            set_fifo(i);
            tick();
        end
        check("p1_below_thr", 32'(ctrl_state), 1);
        set_fifo(64);
        tick();
        check("p1_stream", 32'(ctrl_state), 2);
        check("p1_gate", 32'(iq.fifo_rden_gate), 1);
        set_fifo(100);
        iq.pkt_end = 1'b1;
        tick();
        iq.pkt_end = 1'b0;
        check("p1_stream_after_end", 32'(ctrl_state), 2);
        iq.wifi_iq_ready = 1'b1;
        for (int i = 100; i > 0; i--) begin
            set_fifo(i);
            tick();
        end
        check("p1_draining", 32'(ctrl_state), 2);
        check("p1_no_early_done", 32'(iq.tx_done), 0);
        set_fifo(0);
        tick();
        check("p1_idle", 32'(ctrl_state), 0);
        check("p1_done", 32'(iq.tx_done), 1);
        check("p1_active_off", 32'(iq.tx_active), 0);
        check("p1_gate_off", 32'(iq.fifo_rden_gate), 0);
        tick();
        check("p1_done_pulse", 32'(iq.tx_done), 0);
        check("p1_no_underrun", 32'(underrun_cnt), 0);
        iq.wifi_iq_ready = 1'b0;

        // pkt_start and pkt_end together, 10 samples
        iq.pkt_start = 1'b1;
        iq.pkt_end = 1'b1;
        tick();
        iq.pkt_start = 1'b0;
        iq.pkt_end = 1'b0;
        check("p2_prefill", 32'(ctrl_state), 1);
        set_fifo(10);
        tick();
        check("p2_stream_1cyc", 32'(ctrl_state), 2);
        iq.wifi_iq_ready = 1'b1;
        for (int i = 10; i > 0; i--) begin
            set_fifo(i);
            tick();
        end
        check("p2_no_early_done", 32'(iq.tx_done), 0);
        set_fifo(0);
        tick();
        check("p2_done", 32'(iq.tx_done), 1);
        check("p2_idle", 32'(ctrl_state), 0);
        iq.wifi_iq_ready = 1'b0;

        // Zero threshold and underrun
        prefill_thr = 11'd0;
        iq.pkt_start = 1'b1;
        tick();
        iq.pkt_start = 1'b0;
        check("p3_prefill", 32'(ctrl_state), 1);
        tick();
        check("p3_thr0_stream", 32'(ctrl_state), 2);
        iq.wifi_iq_ready = 1'b1;
        repeat (5) tick();
        iq.wifi_iq_ready = 1'b0;
`ifdef TX_IQ_CTRL_UNDERRUN_CNT_EN
        check("p3_underrun5", 32'(underrun_cnt), 5);
        tick();
        check("p3_underrun_hold", 32'(underrun_cnt), 5);
        iq.wifi_iq_ready = 1'b1;
        repeat (65535) tick();
        iq.wifi_iq_ready = 1'b0;
        check("p3_underrun_sat", 32'(underrun_cnt), 32'hFFFF);
        tick();
        check("p3_underrun_sat_hold", 32'(underrun_cnt), 32'hFFFF);
`else
        check("p3_underrun_tied", 32'(underrun_cnt), 0);
        tick();
`endif
        iq.pkt_end = 1'b1;
        tick();
        iq.pkt_end = 1'b0;
        check("p3_idle", 32'(ctrl_state), 0);
        check("p3_done", 32'(iq.tx_done), 1);

        // Source switch in IDLE
        src_sel_req = 1'b1;
        tick();
        check("s1_flush_state", 32'(ctrl_state), 3);
        check("s1_flush", 32'(iq.fifo_flush), 1);
        check("s1_hold_flush", 32'(iq.tx_hold), 1);
        check("s1_src_old", 32'(src_sel), 0);
        tick();
        check("s1_settle", 32'(ctrl_state), 4);
        check("s1_flush_off", 32'(iq.fifo_flush), 0);
        check("s1_src_new", 32'(src_sel), 1);
        check("s1_hold_settle1", 32'(iq.tx_hold), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s1_settle_n", 32'(ctrl_state), 4);
            check("s1_hold_settle_n", 32'(iq.tx_hold), 1);
        end
        tick();
        check("s1_idle", 32'(ctrl_state), 0);
        check("s1_hold_off", 32'(iq.tx_hold), 0);

        // Source toggle together with pkt_start: packet first, flush afterwards
        src_sel_req = 1'b0;
        iq.pkt_start = 1'b1;
        tick();
        iq.pkt_start = 1'b0;
        check("s2_prefill", 32'(ctrl_state), 1);
        check("s2_no_flush", 32'(iq.fifo_flush), 0);
        set_fifo(5);
        iq.pkt_end = 1'b1;
        tick();
        iq.pkt_end = 1'b0;
        check("s2_stream", 32'(ctrl_state), 2);
        check("s2_gate_src1", 32'(iq.fifo_rden_gate), 0);
        set_fifo(0);
        tick();
        check("s2_done", 32'(iq.tx_done), 1);
        tick();
        check("s2_flush_after", 32'(ctrl_state), 3);
        check("s2_flush_pulse", 32'(iq.fifo_flush), 1);
        repeat (5) tick();
        check("s2_idle", 32'(ctrl_state), 0);
        check("s2_src0", 32'(src_sel), 0);

        // tx_hold threshold boundary
        hold_thr = 11'd50;
        set_fifo(51);
        tick();
        check("h_above", 32'(iq.tx_hold), 1);
        set_fifo(50);
        tick();
        check("h_equal", 32'(iq.tx_hold), 0);
        hold_thr = 11'd2000;

        // Reset mid-packet
        set_fifo(3);
        iq.pkt_start = 1'b1;
        tick();
        iq.pkt_start = 1'b0;
        tick();
        check("r_stream", 32'(ctrl_state), 2);
        check("r_gate", 32'(iq.fifo_rden_gate), 1);
        #2 rst = 1'b1;
        #1;
        check("r_async_state", 32'(ctrl_state), 0);
        check("r_async_gate", 32'(iq.fifo_rden_gate), 0);
        check("r_async_active", 32'(iq.tx_active), 0);
        tick();
        rst = 1'b0;
        set_fifo(0);
        iq.wifi_iq_ready = 1'b1;
        tick();
        check("r_no_done1", 32'(iq.tx_done), 0);
        check("r_idle", 32'(ctrl_state), 0);
        tick();
        check("r_no_done2", 32'(iq.tx_done), 0);
        iq.wifi_iq_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
